// File: rtl/tbt_accumulator_pkg.sv
// Shared definitions for the turn-by-turn accumulator: FSM encoding,
// summing-mode constants and the samples-per-turn clamp.
package tbt_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EXPECT = 2'd2
  } tbt_state_e;

  localparam logic MODE_SIGNED = 1'b0;
  localparam logic MODE_ABS    = 1'b1;

  // A zero turn length behaves as one sample; anything above the bound is capped.
  function automatic int unsigned clamp_samples(input int unsigned n, input int unsigned max_n);
    int unsigned r;
    if (n == 32'd0) begin
      r = 32'd1;
    end else if (n > max_n) begin
      r = max_n;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/tbt_channel_accum.sv
// One channel: sample mode conversion, running accumulator and the
// published per-turn sum register.
module tbt_channel_accum
  import tbt_accumulator_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SUM_WIDTH    = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    add,
  input  logic                    publish,
  input  logic                    mode,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [SUM_WIDTH-1:0]    sum
);

  logic [SAMPLE_WIDTH:0]  mag_s;
  logic [SUM_WIDTH-1:0]   conv_s;
  logic [SUM_WIDTH-1:0]   acc_d, acc_q;
  logic [SUM_WIDTH-1:0]   out_d, out_q;

  // Magnitude is one bit wider so the most negative sample converts without saturating.
  always_comb begin
    if (sample[SAMPLE_WIDTH-1]) begin
      mag_s = {(SAMPLE_WIDTH+1){1'b0}} - {1'b1, sample};
    end else begin
      mag_s = {1'b0, sample};
    end
    if (mode == MODE_ABS) begin
      conv_s = SUM_WIDTH'(mag_s);
    end else begin
      conv_s = SUM_WIDTH'($signed(sample));
    end
    if (load) begin
      acc_d = conv_s;
    end else if (add) begin
      acc_d = acc_q + conv_s;
    end else begin
      acc_d = acc_q;
    end
    if (publish) begin
      out_d = acc_d;
    end else begin
      out_d = out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {SUM_WIDTH{1'b0}};
      out_q <= {SUM_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign sum = out_q;

endmodule

// File: rtl/tbt_accumulator.sv
// Multi-channel turn-by-turn accumulator: marker-aligned turn FSM, sample
// counter, latched turn configuration, turn counter and sticky alignment flags.
module tbt_accumulator
  import tbt_accumulator_pkg::*;
#(
  parameter int CHANNEL_COUNT        = 8,
  parameter int SAMPLE_WIDTH         = 16,
  parameter int MAX_SAMPLES_PER_TURN = 100,
  parameter int COUNT_WIDTH          = $clog2(MAX_SAMPLES_PER_TURN+1),
  parameter int SUM_WIDTH            = SAMPLE_WIDTH + COUNT_WIDTH
) (
  input  logic                                adcClk,
  input  logic                                adcReset,
  input  logic                                enable,
  input  logic [COUNT_WIDTH-1:0]              samplesPerTurn,
  input  logic                                absMode,
  input  logic                                adcValid,
  input  logic                                adcTbtMarker,
  input  logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0] adcData,
  input  logic                                statusClear,
  output logic [CHANNEL_COUNT*SUM_WIDTH-1:0]  tbtSums,
  output logic                                tbtValid,
  output logic [31:0]                         tbtTurnCount,
  output logic                                markerEarly,
  output logic                                markerLate
);

  tbt_state_e             state_d, state_q;
  logic [COUNT_WIDTH-1:0] count_d, count_q;
  logic [COUNT_WIDTH-1:0] n_d, n_q;
  logic                   abs_d, abs_q;
  logic [31:0]            turn_d, turn_q;
  logic                   valid_d, valid_q;
  logic                   early_d, early_q;
  logic                   late_d, late_q;

  logic                   load_s, add_s, publish_s, early_s, late_s, mode_s;
  logic [COUNT_WIDTH-1:0] n_in_s, count_inc_s;

  assign n_in_s      = COUNT_WIDTH'(clamp_samples(32'(samplesPerTurn), 32'(MAX_SAMPLES_PER_TURN)));
  assign count_inc_s = count_q + COUNT_WIDTH'(1);

  // Next-state, turn control and status flag logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    n_d       = n_q;
    abs_d     = abs_q;
    load_s    = 1'b0;
    add_s     = 1'b0;
    publish_s = 1'b0;
    early_s   = 1'b0;
    late_s    = 1'b0;
    if (!enable) begin
      state_d = ST_SYNC;
      count_d = {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (adcValid && adcTbtMarker) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_ACCUM: begin
          if (adcValid && adcTbtMarker) begin
            early_s = 1'b1;
            load_s  = 1'b1;
          end else if (adcValid) begin
            add_s   = 1'b1;
            count_d = count_inc_s;
            if (count_inc_s == n_q) begin
              publish_s = 1'b1;
              state_d   = ST_EXPECT;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_EXPECT: begin
          if (adcValid && adcTbtMarker) begin
            load_s = 1'b1;
          end else if (adcValid) begin
            late_s  = 1'b1;
            state_d = ST_SYNC;
            count_d = {COUNT_WIDTH{1'b0}};
          end else begin
            state_d = ST_EXPECT;
          end
        end
        default: begin
          state_d = ST_SYNC;
          count_d = {COUNT_WIDTH{1'b0}};
        end
      endcase
      // Every turn start (fresh, restarted after an early marker, or back-to-back) lands here.
      if (load_s) begin
        count_d = COUNT_WIDTH'(1);
        n_d     = n_in_s;
        abs_d   = absMode;
        if (n_in_s == COUNT_WIDTH'(1)) begin
          publish_s = 1'b1;
          state_d   = ST_EXPECT;
        end else begin
          state_d = ST_ACCUM;
        end
      end else begin
        abs_d = abs_q;
      end
    end
    mode_s  = load_s ? absMode : abs_q;
    valid_d = publish_s;
    turn_d  = publish_s ? (turn_q + 32'd1) : turn_q;
    if (early_s) begin
      early_d = 1'b1;
    end else if (statusClear) begin
      early_d = 1'b0;
    end else begin
      early_d = early_q;
    end
    if (late_s) begin
      late_d = 1'b1;
    end else if (statusClear) begin
      late_d = 1'b0;
    end else begin
      late_d = late_q;
    end
  end

  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      state_q <= ST_SYNC;
      count_q <= {COUNT_WIDTH{1'b0}};
      n_q     <= COUNT_WIDTH'(1);
      abs_q   <= MODE_SIGNED;
      turn_q  <= 32'd0;
      valid_q <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      abs_q   <= abs_d;
      turn_q  <= turn_d;
      valid_q <= valid_d;
      early_q <= early_d;
      late_q  <= late_d;
    end
  end

  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_ch
    tbt_channel_accum #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .SUM_WIDTH    (SUM_WIDTH)
    ) u_ch (
      .clk     (adcClk),
      .rst     (adcReset),
      .load    (load_s),
      .add     (add_s),
      .publish (publish_s),
      .mode    (mode_s),
      .sample  (adcData[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .sum     (tbtSums[gi*SUM_WIDTH +: SUM_WIDTH])
    );
  end

  assign tbtValid     = valid_q;
  assign tbtTurnCount = turn_q;
  assign markerEarly  = early_q;
  assign markerLate   = late_q;

endmodule
